pll_lock_monitor: RTL



---
 rtl/pll_lock_monitor_if.sv | 31 +++
 rtl/pll_lock_monitor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor_if.sv
// pll_lock_monitor_if: groups the PLL status inputs and the lock/measurement
// outputs of pll_lock_monitor into one bundle.
//   pll_lock   PLL LOCK flag, asynchronous to clk
//   tog        divided toggle from the clkout domain, asynchronous to clk
//   locked     frequency-qualified lock
//   rst_out    downstream core reset, active-high, always ~locked
//   meas_cnt   edge count of the last completed window
//   meas_valid one-cycle pulse when meas_cnt updates
//   fault      sticky lock-loss / frequency-error flag
// modport master: the monitor itself; modport slave: the PLL/core side.
interface pll_lock_monitor_if #(
   parameter int unsigned CNT_W = 16
);
   logic             pll_lock;
   logic             tog;
   logic             locked;
   logic             rst_out;
   logic [CNT_W-1:0] meas_cnt;
   logic             meas_valid;
   logic             fault;

   modport master (
      input  pll_lock, tog,
      output locked, rst_out, meas_cnt, meas_valid, fault
   );

   modport slave (
      output pll_lock, tog,
      input  locked, rst_out, meas_cnt, meas_valid, fault
   );
endinterface

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: qualifies the rPLL LOCK flag from the reference-clock side,
// counts rising edges of a divided clkout toggle over fixed gate windows and
// releases the downstream reset only after GOOD_WINDOWS consecutive in-range
// windows. Lock loss or a frequency excursion while running re-asserts reset
// and latches fault.
// Ports:
//   clk  reference clock (PLL clkin net)
//   rst  synchronous active-high reset
//   bus  pll_lock_monitor_if.master (pll_lock, tog in; locked, rst_out,
//        meas_cnt, meas_valid, fault out -- all outputs registered)
module pll_lock_monitor #(
   parameter int unsigned GATE_CYCLES  = 27000,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned EXP_MIN      = 1680,
   parameter int unsigned EXP_MAX      = 1695,
   parameter int unsigned GOOD_WINDOWS = 4
) (
   input  logic                clk,
   input  logic                rst,
   pll_lock_monitor_if.master  bus
);

   localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
   localparam logic [CNT_W-1:0]  EXP_MIN_C = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0]  EXP_MAX_C = CNT_W'(EXP_MAX);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      MEASURE   = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t            state;
   logic              lock_m, lock_s;
   logic              tog_m, tog_s, tog_d;
   logic [GATE_W-1:0] gate;
   logic [CNT_W-1:0]  edges;
   logic [CNT_W-1:0]  edges_nxt;
   logic [GOOD_W-1:0] good;
   logic              locked, rst_out, meas_valid, fault;
   logic [CNT_W-1:0]  meas_cnt;
   logic              rise, close, in_range;

   assign rise  = tog_s & ~tog_d;
   assign close = (gate == GATE_LAST);

   // Saturating edge count including any edge seen this cycle, so an edge on
   // the closing cycle lands in the closing window.
   always_comb begin
      edges_nxt = edges;
      if (rise && (edges != '1)) begin
         edges_nxt = edges + CNT_W'(1);
      end
   end

   assign in_range = (edges_nxt >= EXP_MIN_C) && (edges_nxt <= EXP_MAX_C);

   // Synchronizers, window counters and lock-qualification FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_LOCK;
         lock_m     <= 1'b0;
         lock_s     <= 1'b0;
         tog_m      <= 1'b0;
         tog_s      <= 1'b0;
         tog_d      <= 1'b0;
         gate       <= '0;
         edges      <= '0;
         good       <= '0;
         locked     <= 1'b0;
         rst_out    <= 1'b1;
         meas_cnt   <= '0;
         meas_valid <= 1'b0;
         fault      <= 1'b0;
      end else begin
         lock_m     <= bus.pll_lock;
         lock_s     <= lock_m;
         tog_m      <= bus.tog;
         tog_s      <= tog_m;
         tog_d      <= tog_s;
         meas_valid <= 1'b0;

         case (state)
            WAIT_LOCK: begin
               gate  <= '0;
               edges <= '0;
               good  <= '0;
               if (lock_s) begin
                  state <= MEASURE;
               end
            end

            MEASURE, RUN: begin
               if (!lock_s) begin
                  // Lock loss beats a coincident window close: window dropped.
                  state   <= WAIT_LOCK;
                  gate    <= '0;
                  edges   <= '0;
                  good    <= '0;
                  locked  <= 1'b0;
                  rst_out <= 1'b1;
                  if (state == RUN) begin
                     fault <= 1'b1;
                  end
               end else if (close) begin
                  gate       <= '0;
                  edges      <= '0;
                  meas_cnt   <= edges_nxt;
                  meas_valid <= 1'b1;
                  if (state == MEASURE) begin
                     if (!in_range) begin
                        good <= '0;
                     end else begin
                        good <= good + GOOD_W'(1);
                        if (good == GOOD_LAST) begin
                           state   <= RUN;
                           locked  <= 1'b1;
                           rst_out <= 1'b0;
                        end
                     end
                  end else if (!in_range) begin
                     state   <= WAIT_LOCK;
                     good    <= '0;
                     locked  <= 1'b0;
                     rst_out <= 1'b1;
                     fault   <= 1'b1;
                  end
               end else begin
                  gate  <= gate + GATE_W'(1);
                  edges <= edges_nxt;
               end
            end

            default: begin
               state <= WAIT_LOCK;
            end
         endcase
      end
   end

   assign bus.locked     = locked;
   assign bus.rst_out    = rst_out;
   assign bus.meas_cnt   = meas_cnt;
   assign bus.meas_valid = meas_valid;
   assign bus.fault      = fault;

endmodule
